// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count window sequencer.
// Build option: COINC_EN adds an all-channel coincidence beat to every drain.
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int OUT_CH_W = 4;
  localparam int MAX_CH   = 8;

  function automatic int beats_per_drain(input int num_ch);
`ifdef COINC_EN
    return num_ch + 1;
`else
    return num_ch;
`endif
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with clear. The sum output is the count including
// this cycle's increment, so a snapshot taken on the clearing edge loses nothing.
module sat_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         clr_inc,
  output logic [W-1:0] sum,
  output logic         sum_sat
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;
  logic         at_max;

  // sat marks that at least one increment was dropped at full scale
  always_comb begin
    at_max  = (count_q == {W{1'b1}});
    sum     = count_q;
    if (inc && !at_max) sum = count_q + W'(1);
    sum_sat = sat_q | (inc & at_max);
    if (clr) begin
      count_d = W'(clr_inc);
      sat_d   = 1'b0;
    end else begin
      count_d = sum;
      sat_d   = sum_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: rtl/count_window_sequencer.sv
// Counts shaped pulses over back-to-back windows and streams each window's
// snapshot out as valid/ready beats. Build option: COINC_EN (coincidence beat).
module count_window_sequencer
  import count_seq_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 24,
  parameter int WIN_W  = 32,
  parameter int NWIN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WIN_W-1:0]    window_len,
  input  logic [NWIN_W-1:0]   num_windows,
  input  logic [NUM_CH-1:0]   pulse,
  output logic                busy,
  output logic                win_tick,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NWIN_W-1:0]   out_win,
  output logic [OUT_CH_W-1:0] out_ch,
  output logic [CNT_W-1:0]    out_count,
  output logic                out_sat,
  output logic                overrun,
  output logic                done
);

  localparam int NBEAT = beats_per_drain(NUM_CH);
  localparam logic [OUT_CH_W-1:0] LAST_BEAT = OUT_CH_W'(NBEAT - 1);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("NUM_CH out of range");
  end

  state_e                         state_q, state_d;
  logic [WIN_W-1:0]               len_q, len_d;
  logic [WIN_W-1:0]               cyc_q, cyc_d;
  logic [NWIN_W-1:0]              nwin_q, nwin_d;
  logic [NWIN_W-1:0]              win_q, win_d;
  logic [NWIN_W-1:0]              snap_win_q, snap_win_d;
  logic [NBEAT-1:0][CNT_W-1:0]    snap_cnt_q, snap_cnt_d;
  logic [NBEAT-1:0]               snap_sat_q, snap_sat_d;
  logic                           drain_q, drain_d;
  logic [OUT_CH_W-1:0]            beat_q, beat_d;
  logic                           overrun_q, overrun_d;

  logic [NBEAT-1:0]               inc_vec;
  logic [NBEAT-1:0][CNT_W-1:0]    sum_vec;
  logic [NBEAT-1:0]               sum_sat_vec;
  logic counting, tick, last_win, hs, drain_end, load_ok, start_acc, clr;

  always_comb begin
    counting  = (state_q == ST_COUNT);
    tick      = counting && (cyc_q == len_q - WIN_W'(1));
    last_win  = (win_q == nwin_q - NWIN_W'(1));
    hs        = drain_q && out_ready;
    drain_end = hs && (beat_q == LAST_BEAT);
    load_ok   = !drain_q || drain_end;
    start_acc = (state_q == ST_IDLE) && start && !abort;
    clr       = abort || start_acc || tick;
    inc_vec   = '0;
    for (int i = 0; i < NUM_CH; i++) inc_vec[i] = pulse[i] & counting;
`ifdef COINC_EN
    inc_vec[NUM_CH] = (&pulse) & counting;
`endif
  end

  // Pulses on the boundary edge belong to the ending window, so a cleared
  // counter always restarts from zero.
  for (genvar g = 0; g < NBEAT; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_vec[g]),
      .clr     (clr),
      .clr_inc (1'b0),
      .sum     (sum_vec[g]),
      .sum_sat (sum_sat_vec[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cyc_d      = cyc_q;
    nwin_d     = nwin_q;
    win_d      = win_q;
    snap_win_d = snap_win_q;
    snap_cnt_d = snap_cnt_q;
    snap_sat_d = snap_sat_q;
    drain_d    = drain_q;
    beat_d     = beat_q;
    overrun_d  = overrun_q;

    if (abort) begin
      state_d = ST_IDLE;
      drain_d = 1'b0;
      beat_d  = '0;
    end else begin
      if (hs) begin
        if (drain_end) begin
          drain_d = 1'b0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + OUT_CH_W'(1);
        end
      end
      // A window ending mid-drain is dropped so the pending snapshot stays intact
      if (tick) begin
        if (load_ok) begin
          snap_cnt_d = sum_vec;
          snap_sat_d = sum_sat_vec;
          snap_win_d = win_q;
          drain_d    = 1'b1;
          beat_d     = '0;
        end else begin
          overrun_d = 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d      = (window_len == '0) ? WIN_W'(1) : window_len;
            nwin_d     = num_windows;
            cyc_d      = '0;
            win_d      = '0;
            snap_win_d = '0;
            snap_cnt_d = '0;
            snap_sat_d = '0;
            drain_d    = 1'b0;
            beat_d     = '0;
            overrun_d  = 1'b0;
            state_d    = (num_windows == '0) ? ST_DONE : ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (tick) begin
            cyc_d = '0;
            win_d = win_q + NWIN_W'(1);
            if (last_win) state_d = ST_FLUSH;
          end else begin
            cyc_d = cyc_q + WIN_W'(1);
          end
        end
        ST_FLUSH: begin
          if (!drain_d) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cyc_q      <= '0;
      nwin_q     <= '0;
      win_q      <= '0;
      snap_win_q <= '0;
      snap_cnt_q <= '0;
      snap_sat_q <= '0;
      drain_q    <= 1'b0;
      beat_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cyc_q      <= cyc_d;
      nwin_q     <= nwin_d;
      win_q      <= win_d;
      snap_win_q <= snap_win_d;
      snap_cnt_q <= snap_cnt_d;
      snap_sat_q <= snap_sat_d;
      drain_q    <= drain_d;
      beat_q     <= beat_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    out_count = '0;
    out_sat   = 1'b0;
    for (int i = 0; i < NBEAT; i++) begin
      if (beat_q == OUT_CH_W'(i)) begin
        out_count = snap_cnt_q[i];
        out_sat   = snap_sat_q[i];
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign win_tick  = tick;
  assign out_valid = drain_q;
  assign out_ch    = beat_q;
  assign out_win   = snap_win_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_count_window_sequencer.sv
// Self-checking bench for count_window_sequencer; build with +define+COINC_EN
// to exercise the coincidence beat.
module tb_count_window_sequencer;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 16;
  localparam int NWIN_W = 8;
  localparam int MAXR   = 1024;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef COINC_EN
  localparam int NBEAT = NUM_CH + 1;
`else
  localparam int NBEAT = NUM_CH;
`endif

  typedef struct {
    int win;
    int ch;
    int cnt;
    bit sat;
    int r;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic [WIN_W-1:0]  window_len = '0;
  logic [NWIN_W-1:0] num_windows = '0;
  logic [NUM_CH-1:0] pulse = '0;
  logic              busy, win_tick, out_valid, out_sat, overrun, done;
  logic [NWIN_W-1:0] out_win;
  logic [3:0]        out_ch;
  logic [CNT_W-1:0]  out_count;

  count_window_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .NWIN_W(NWIN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .window_len(window_len), .num_windows(num_windows), .pulse(pulse),
    .busy(busy), .win_tick(win_tick), .out_valid(out_valid), .out_ready(out_ready),
    .out_win(out_win), .out_ch(out_ch), .out_count(out_count), .out_sat(out_sat),
    .overrun(overrun), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus patterns indexed by edge number relative to the start edge (r=0)
  bit [NUM_CH-1:0] pulse_pat [MAXR];
  bit              ready_pat [MAXR];

  beat_t got_q[$], exp_q[$];
  int    got_tick[$], exp_tick[$];
  int    got_done_rel, got_done_cnt, exp_done_rel;
  bit    exp_ov;

  function automatic void clear_pat(input bit rdy);
    for (int r = 0; r < MAXR; r++) begin
      pulse_pat[r] = '0;
      ready_pat[r] = rdy;
    end
  endfunction

  // Start a run, replay the patterns and log beats, ticks and done by edge
  task automatic run_capture(input int len, input int nwin, input int budget);
    beat_t b;
    got_q.delete();
    got_tick.delete();
    got_done_rel = -1;
    got_done_cnt = 0;
    @(negedge clk);
    window_len  = WIN_W'(len);
    num_windows = NWIN_W'(nwin);
    start       = 1'b1;
    pulse       = '0;
    out_ready   = ready_pat[0];
    for (int r = 1; r < budget; r++) begin
      @(negedge clk);
      start     = 1'b0;
      pulse     = pulse_pat[r];
      out_ready = ready_pat[r];
      if (out_valid && out_ready) begin
        b.win = int'(out_win);
        b.ch  = int'(out_ch);
        b.cnt = int'(out_count);
        b.sat = out_sat;
        b.r   = r;
        got_q.push_back(b);
      end
      if (win_tick) got_tick.push_back(r);
      if (done) begin
        got_done_cnt++;
        got_done_rel = r - 1;
      end
      if (got_done_rel >= 0 && r > got_done_rel + 3) break;
    end
    pulse     = '0;
    out_ready = 1'b1;
  endtask

  // Reference: window k spans edges kL+1..(k+1)L; a window is kept only when
  // the previous kept window finished draining by its closing edge.
  function automatic void build_expected(input int len, input int nwin);
    int leff;
    int f;
    int sums[NBEAT];
    beat_t b;
    leff = (len == 0) ? 1 : len;
    f = 0;
    exp_q.delete();
    exp_tick.delete();
    exp_ov = 1'b0;
    for (int k = 0; k < nwin; k++) begin
      int e;
      e = (k + 1) * leff;
      exp_tick.push_back(e);
      if (f > e) begin
        exp_ov = 1'b1;
        continue;
      end
      for (int i = 0; i < NBEAT; i++) sums[i] = 0;
      for (int r = k * leff + 1; r <= e; r++) begin
        for (int c = 0; c < NUM_CH; c++) sums[c] += int'(pulse_pat[r][c]);
`ifdef COINC_EN
        if (&pulse_pat[r]) sums[NUM_CH]++;
`endif
      end
      f = e;
      for (int i = 0; i < NBEAT; i++) begin
        f++;
        while (f < MAXR - 1 && !ready_pat[f]) f++;
        b.win = k;
        b.ch  = i;
        b.cnt = (sums[i] > CMAX) ? CMAX : sums[i];
        b.sat = (sums[i] > CMAX);
        b.r   = f;
        exp_q.push_back(b);
      end
    end
    exp_done_rel = f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
    n_checks++; if (win_tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", win_tick); else n_pass++;
    n_checks++; if (out_count !== '0) $display("[TB] FAIL reset_count: got %0d expected 0", out_count); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w, c, ec;
    clear_pat(1'b1);
    for (int r = 2; r < MAXR; r += 2) pulse_pat[r] = 2'b01;
    run_capture(10, 3, 200);
    n_checks++; if (got_q.size() !== 3 * NBEAT) $display("[TB] FAIL basic_beats: got %0d expected %0d", got_q.size(), 3 * NBEAT); else n_pass++;
    foreach (got_q[i]) begin
      w  = i / NBEAT;
      c  = i % NBEAT;
      ec = (c == 0) ? 5 : 0;
      n_checks++;
      if (got_q[i].win !== w || got_q[i].ch !== c || got_q[i].cnt !== ec || got_q[i].sat !== 1'b0 || got_q[i].r !== 10 * (w + 1) + 1 + c)
        $display("[TB] FAIL basic_beat%0d: got w%0d ch%0d cnt%0d sat%0d edge%0d expected w%0d ch%0d cnt%0d sat0 edge%0d",
                 i, got_q[i].win, got_q[i].ch, got_q[i].cnt, got_q[i].sat, got_q[i].r, w, c, ec, 10 * (w + 1) + 1 + c);
      else n_pass++;
    end
    n_checks++; if (got_tick.size() !== 3) $display("[TB] FAIL basic_ticks: got %0d expected 3", got_tick.size()); else n_pass++;
    foreach (got_tick[i]) begin
      n_checks++; if (got_tick[i] !== 10 * (i + 1)) $display("[TB] FAIL basic_tick%0d: got edge %0d expected %0d", i, got_tick[i], 10 * (i + 1)); else n_pass++;
    end
    n_checks++; if (got_done_cnt !== 1) $display("[TB] FAIL basic_done_cnt: got %0d expected 1", got_done_cnt); else n_pass++;
    n_checks++; if (got_done_rel !== 30 + NBEAT) $display("[TB] FAIL basic_done_time: got %0d expected %0d", got_done_rel, 30 + NBEAT); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("[TB] FAIL basic_overrun: got %b expected 0", overrun); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_idle: got busy %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_boundary();
    int ec;
    clear_pat(1'b1);
    pulse_pat[5]  = 2'b01;
    pulse_pat[6]  = 2'b01;
    pulse_pat[1]  = 2'b10;
    pulse_pat[10] = 2'b10;
    run_capture(5, 2, 100);
    n_checks++; if (got_q.size() !== 2 * NBEAT) $display("[TB] FAIL boundary_beats: got %0d expected %0d", got_q.size(), 2 * NBEAT); else n_pass++;
    foreach (got_q[i]) begin
      ec = (got_q[i].ch < NUM_CH) ? 1 : 0;
      n_checks++;
      if (got_q[i].cnt !== ec || got_q[i].win !== i / NBEAT)
        $display("[TB] FAIL boundary_beat%0d: got w%0d cnt%0d expected w%0d cnt%0d", i, got_q[i].win, got_q[i].cnt, i / NBEAT, ec);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    clear_pat(1'b1);
    for (int r = 1; r <= 20; r++) pulse_pat[r] = 2'b01;
    run_capture(20, 1, 100);
    n_checks++; if (got_q.size() !== NBEAT) $display("[TB] FAIL sat_beats: got %0d expected %0d", got_q.size(), NBEAT); else n_pass++;
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0].cnt !== CMAX || got_q[0].sat !== 1'b1) $display("[TB] FAIL sat_ch0: got cnt%0d sat%0d expected cnt%0d sat1", got_q[0].cnt, got_q[0].sat, CMAX); else n_pass++;
      n_checks++; if (got_q[1].cnt !== 0 || got_q[1].sat !== 1'b0) $display("[TB] FAIL sat_ch1: got cnt%0d sat%0d expected cnt0 sat0", got_q[1].cnt, got_q[1].sat); else n_pass++;
    end
  endtask

  task automatic test_zero_windows();
    clear_pat(1'b1);
    run_capture(5, 0, 20);
    n_checks++; if (got_done_rel !== 0) $display("[TB] FAIL zero_done_time: got %0d expected 0", got_done_rel); else n_pass++;
    n_checks++; if (got_done_cnt !== 1) $display("[TB] FAIL zero_done_cnt: got %0d expected 1", got_done_cnt); else n_pass++;
    n_checks++; if (got_q.size() !== 0) $display("[TB] FAIL zero_beats: got %0d expected 0", got_q.size()); else n_pass++;
  endtask

`ifdef COINC_EN
  task automatic test_coinc();
    clear_pat(1'b1);
    for (int r = 1; r <= 4; r++) pulse_pat[r] = 2'b11;
    run_capture(8, 1, 100);
    n_checks++; if (got_q.size() !== 3) $display("[TB] FAIL coinc_beats: got %0d expected 3", got_q.size()); else n_pass++;
    if (got_q.size() == 3) begin
      n_checks++; if (got_q[2].ch !== 2 || got_q[2].cnt !== 4) $display("[TB] FAIL coinc_beat: got ch%0d cnt%0d expected ch2 cnt4", got_q[2].ch, got_q[2].cnt); else n_pass++;
      n_checks++; if (got_q[0].cnt !== 4) $display("[TB] FAIL coinc_ch0: got %0d expected 4", got_q[0].cnt); else n_pass++;
    end
  endtask
`endif

  task automatic test_overrun();
    int lost;
    clear_pat(1'b1);
    for (int r = 1; r < MAXR; r++) pulse_pat[r] = 2'b01;
    for (int r = 0; r <= 10; r++) ready_pat[r] = 1'b0;
    run_capture(3, 4, 100);
    n_checks++; if (overrun !== 1'b1) $display("[TB] FAIL overrun_flag: got %b expected 1", overrun); else n_pass++;
    n_checks++; if (got_tick.size() !== 4) $display("[TB] FAIL overrun_ticks: got %0d expected 4", got_tick.size()); else n_pass++;
    if (got_q.size() >= 2) begin
      n_checks++;
      if (got_q[0].win !== 0 || got_q[0].ch !== 0 || got_q[0].cnt !== 3 || got_q[0].r !== 11)
        $display("[TB] FAIL overrun_beat0: got w%0d ch%0d cnt%0d edge%0d expected w0 ch0 cnt3 edge11", got_q[0].win, got_q[0].ch, got_q[0].cnt, got_q[0].r);
      else n_pass++;
      n_checks++;
      if (got_q[1].win !== 0 || got_q[1].ch !== 1 || got_q[1].cnt !== 0 || got_q[1].r !== 12)
        $display("[TB] FAIL overrun_beat1: got w%0d ch%0d cnt%0d edge%0d expected w0 ch1 cnt0 edge12", got_q[1].win, got_q[1].ch, got_q[1].cnt, got_q[1].r);
      else n_pass++;
    end else begin
      n_checks++; $display("[TB] FAIL overrun_w0_beats: got %0d beats expected at least 2", got_q.size());
    end
    lost = 0;
    foreach (got_q[i]) if (got_q[i].win == 1 || got_q[i].win == 2) lost++;
    n_checks++; if (lost !== 0) $display("[TB] FAIL overrun_lost_emitted: got %0d beats expected 0", lost); else n_pass++;
    n_checks++; if (got_done_cnt !== 1) $display("[TB] FAIL overrun_done: got %0d expected 1", got_done_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    int dn;
    n_checks++; if (overrun !== 1'b1) $display("[TB] FAIL abort_prev_overrun_held: got %b expected 1", overrun); else n_pass++;
    clear_pat(1'b0);
    for (int r = 1; r < 40; r++) pulse_pat[r] = NUM_CH'($urandom);
    @(negedge clk);
    window_len  = WIN_W'(10);
    num_windows = NWIN_W'(4);
    start       = 1'b1;
    out_ready   = 1'b0;
    for (int r = 1; r <= 15; r++) begin
      @(negedge clk);
      start = 1'b0;
      pulse = pulse_pat[r];
    end
    n_checks++; if (overrun !== 1'b0) $display("[TB] FAIL abort_start_clears_overrun: got %b expected 0", overrun); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL abort_stalled_valid: got %b expected 1", out_valid); else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pulse = '0;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL abort_valid: got %b expected 0", out_valid); else n_pass++;
    dn = 0;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    n_checks++; if (dn !== 0) $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", dn); else n_pass++;
    clear_pat(1'b1);
    for (int r = 1; r < 40; r++) pulse_pat[r] = NUM_CH'($urandom);
    run_capture(6, 2, 200);
    build_expected(6, 2);
    n_checks++; if (overrun !== 1'b0) $display("[TB] FAIL abort_rerun_overrun: got %b expected 0", overrun); else n_pass++;
    n_checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL abort_rerun_beats: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (got_done_rel !== exp_done_rel) $display("[TB] FAIL abort_rerun_done: got %0d expected %0d", got_done_rel, exp_done_rel); else n_pass++;
  endtask

  task automatic test_random();
    int len, nwin, n;
    for (int it = 0; it < 8; it++) begin
      len  = $urandom_range(0, 20);
      nwin = $urandom_range(1, 5);
      clear_pat(1'b1);
      for (int r = 1; r < MAXR; r++) begin
        pulse_pat[r][0] = ($urandom_range(0, 99) < 85);
        for (int c = 1; c < NUM_CH; c++) pulse_pat[r][c] = ($urandom_range(0, 99) < 50);
        if (r < 400) ready_pat[r] = ($urandom_range(0, 99) < 65);
      end
      run_capture(len, nwin, 900);
      build_expected(len, nwin);
      n_checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL rand%0d_beats: got %0d expected %0d (L=%0d N=%0d)", it, got_q.size(), exp_q.size(), len, nwin); else n_pass++;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (got_q[i].win !== exp_q[i].win || got_q[i].ch !== exp_q[i].ch || got_q[i].cnt !== exp_q[i].cnt ||
            got_q[i].sat !== exp_q[i].sat || got_q[i].r !== exp_q[i].r)
          $display("[TB] FAIL rand%0d_beat%0d: got w%0d ch%0d cnt%0d sat%0d edge%0d expected w%0d ch%0d cnt%0d sat%0d edge%0d",
                   it, i, got_q[i].win, got_q[i].ch, got_q[i].cnt, got_q[i].sat, got_q[i].r,
                   exp_q[i].win, exp_q[i].ch, exp_q[i].cnt, exp_q[i].sat, exp_q[i].r);
        else n_pass++;
      end
      n_checks++; if (got_tick.size() !== exp_tick.size()) $display("[TB] FAIL rand%0d_ticks: got %0d expected %0d", it, got_tick.size(), exp_tick.size()); else n_pass++;
      n = (got_tick.size() < exp_tick.size()) ? got_tick.size() : exp_tick.size();
      for (int i = 0; i < n; i++) begin
        n_checks++; if (got_tick[i] !== exp_tick[i]) $display("[TB] FAIL rand%0d_tick%0d: got edge %0d expected %0d", it, i, got_tick[i], exp_tick[i]); else n_pass++;
      end
      n_checks++; if (overrun !== exp_ov) $display("[TB] FAIL rand%0d_overrun: got %b expected %b", it, overrun, exp_ov); else n_pass++;
      n_checks++; if (got_done_rel !== exp_done_rel) $display("[TB] FAIL rand%0d_done_time: got %0d expected %0d", it, got_done_rel, exp_done_rel); else n_pass++;
      n_checks++; if (got_done_cnt !== 1) $display("[TB] FAIL rand%0d_done_cnt: got %0d expected 1", it, got_done_cnt); else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before the test sequence completed");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_saturation();
    test_zero_windows();
`ifdef COINC_EN
    test_coinc();
`endif
    test_overrun();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_window_sequencer.md
# count_window_sequencer

Sequences the photon-counting datapath for single-pixel imaging. Takes the one-cycle pulses from the per-channel pulse shapers and counts them over back-to-back integration windows, one window per illumination pattern. At each window boundary it snapshots all channel counts and streams them out over a valid/ready interface. Counting continues into the next window with zero dead time. It sits between the pulse shapers and the readout/host FIFO.

## Interface
- NUM_CH, 2: number of shaped pulse inputs (1..8)
- CNT_W, 24: per-channel count width
- WIN_W, 32: window length width (cycles)
- NWIN_W, 16: window count width

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  return to IDLE next cycle from any state
- window_len  in  WIN_W  cycles per window; latched on start; 0 treated as 1
- num_windows  in  NWIN_W  windows per run; latched on start
- pulse  in  NUM_CH  shaped pulses, one bit per channel, counted when high on a sampled edge
- busy  out  1  high in every state except IDLE
- win_tick  out  1  one-cycle strobe in the last cycle of each window
- out_valid  out  1  readout beat valid
- out_ready  in  1  readout consumer ready
- out_win  out  NWIN_W  window index of beat
- out_ch  out  4  channel index of beat
- out_count  out  CNT_W  count of beat
- out_sat  out  1  this count saturated
- overrun  out  1  sticky; a snapshot was lost; cleared on start
- done  out  1  one-cycle strobe when run completes

## Operation
- States: IDLE, COUNT, FLUSH, DONE.
- IDLE: `start` latches `window_len` and `num_windows`, clears live counters, snapshot, `overrun` and the window index. The next state is COUNT. If `num_windows`=0, the next state is DONE.
- COUNT: a window-cycle counter runs 0..window_len-1.
  - Each channel's live counter increments when its `pulse` bit is high. It saturates at 2^CNT_W-1 and sets a per-channel sat bit.
  - In cycle window_len-1, `win_tick`=1. At that edge, live counts plus that cycle's pulses are copied to the snapshot and live counters restart from 0.
  - After the last window, go to FLUSH. Otherwise the next window starts immediately.
- Drain: the snapshot is emitted as NUM_CH beats, ch 0 first, while the next window counts.
  - A beat transfers on out_valid && out_ready.
  - out_* are held stable while valid && !ready.
- Snapshot conflict: a window ends while the previous snapshot is not fully drained.
  - The new counts are discarded and the old drain continues.
  - overrun is set and live counters are still cleared.
- FLUSH: wait until the drain completes, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort: live counters and drain are cleared and out_valid drops; overrun is held.
- Reset values: all outputs 0, state IDLE.

## Timing
- If start is accepted at edge t, window 0 counts pulses sampled at edges t+1..t+window_len.
- Window k covers edges t+1+k·L..t+(k+1)·L.
- First out_valid appears the cycle after the snapshot edge. With ready held high, one beat per cycle, so NUM_CH cycles per drain.
- No overrun is possible when window_len ≥ NUM_CH+1 and ready is held high.
- done rises 1 cycle after the final beat handshake.
- start during busy is ignored. abort takes priority over every other event in the same cycle.

## Configuration
- COINC_EN defined: adds a coincidence counter that increments when all `pulse` bits are high on the same edge. It is emitted as an extra beat with out_ch=NUM_CH, so a drain is NUM_CH+1 beats.
- COINC_EN undefined: no coincidence logic; NUM_CH beats per drain.

## Structure
- Package count_seq_pkg holds the state enum, the out_ch width constant (4), and the max-channel constant (8).
- Sub-module sat_counter: CNT_W saturating counter with clear and load-to-one-on-clear-with-pulse, plus a sat flag. Instantiated per channel and for coincidence.

## Test plan
- L=10, N=3, ch0 pulses every 2 cycles, ch1 none, ready=1 -> beats (w0,ch0,5),(w0,ch1,0) repeated for w1 and w2. done is seen 1 cycle after the final beat. No overrun.
- Pulse exactly on the last cycle of window 0 and the first cycle of window 1 -> counted once in each window, no loss or double count.
- CNT_W=4, ch0 high for 20 cycles, L=20 -> count=15, out_sat=1.
- L=3, NUM_CH=2, ready=0 for 10 cycles -> overrun=1. The window 0 beats are delivered intact after ready rises, and the later windows lost in the conflict are not emitted.
- abort mid-window 1 of N=4 -> busy=0 next cycle, out_valid=0, no done. A following start runs cleanly with overrun cleared.
- COINC_EN, both channels high for 4 cycles of L=8 -> beat ch=2 count=4. num_windows=0 -> done 1 cycle after start with no beats.
